// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle between the digit-entry register, the BCD converter and the ALU operand latch.
interface bcd_to_bin_seq_if #(
  parameter int NDIG  = 4,
  parameter int WIDTH = 11
);
  logic               in_valid;
  logic               in_ready;
  logic [4*NDIG-1:0]  bcd_in;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   bin_out;
  logic               err_digit;
  logic               err_ovf;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err_digit, err_ovf
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err_digit, err_ovf
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Multi-cycle packed-BCD to signed binary converter: one x10-and-add step per clock,
// with sign digit, invalid-digit flag and overflow saturation.
module bcd_to_bin_seq #(
  parameter int NDIG  = 4,
  parameter int WIDTH = 11
) (
  input  logic            clk,
  input  logic            rst,
  bcd_to_bin_seq_if.slave bus
);
  localparam int AW = WIDTH + 4;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [AW-1:0] LIM_NEG = AW'(1) << (WIDTH - 1);
  localparam logic [AW-1:0] LIM_POS = LIM_NEG - AW'(1);

  typedef enum logic [1:0] {IDLE, CONV, SIGN, DONE} state_t;

  state_t            state, state_n;
  logic [4*NDIG-1:0] word, word_n;
  logic [AW-1:0]     acc, acc_n;
  logic [IW-1:0]     idx, idx_n;
  logic              neg, neg_n;
  logic              ovf, ovf_n;
  logic [WIDTH-1:0]  bin, bin_n;
  logic              err_d, err_d_n;
  logic              err_o, err_o_n;
  logic [3:0]        dig;
  logic [AW-1:0]     acc_x10;

  // The latched word is shifted left each CONV cycle so the slot being processed is always on top.
  assign dig     = word[4*NDIG-1 -: 4];
  assign acc_x10 = (acc << 3) + (acc << 1) + {{(AW-4){1'b0}}, dig};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      word  <= '0;
      acc   <= '0;
      idx   <= '0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
      bin   <= '0;
      err_d <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state <= state_n;
      word  <= word_n;
      acc   <= acc_n;
      idx   <= idx_n;
      neg   <= neg_n;
      ovf   <= ovf_n;
      bin   <= bin_n;
      err_d <= err_d_n;
      err_o <= err_o_n;
    end
  end

  always_comb begin
    state_n = state;
    word_n  = word;
    acc_n   = acc;
    idx_n   = idx;
    neg_n   = neg;
    ovf_n   = ovf;
    bin_n   = bin;
    err_d_n = err_d;
    err_o_n = err_o;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          word_n  = bus.bcd_in;
          acc_n   = '0;
          idx_n   = IW'(NDIG - 1);
          neg_n   = 1'b0;
          ovf_n   = 1'b0;
          err_d_n = 1'b0;
          err_o_n = 1'b0;
          state_n = CONV;
        end
      end
      CONV: begin
        word_n = word << 4;
        idx_n  = idx - IW'(1);
        if (dig <= 4'd9) begin
          acc_n = acc_x10;
          if (|acc_x10[AW-1:WIDTH]) ovf_n = 1'b1;
        end else begin
          case (dig)
            4'hB: begin
              if (neg) err_d_n = 1'b1;
              else     neg_n   = 1'b1;
            end
            4'hA, 4'hF: ;
            default: err_d_n = 1'b1;
          endcase
        end
        if (idx == '0) state_n = SIGN;
      end
      SIGN: begin
        if (ovf || (acc > (neg ? LIM_NEG : LIM_POS))) begin
          bin_n   = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          err_o_n = 1'b1;
        end else begin
          bin_n = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
        state_n = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.bin_out   = bin;
  assign bus.err_digit = err_d;
  assign bus.err_ovf   = err_o;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench: two converter instances (4 digits/11 bits and 5 digits/12 bits),
// table-driven conversions plus back-pressure and mid-conversion reset sequences.
module tb_bcd_to_bin_seq;
  logic clk;
  logic rst;
  int   errors;
  int   total;

  bcd_to_bin_seq_if #(.NDIG(4), .WIDTH(11)) ia ();
  bcd_to_bin_seq_if #(.NDIG(5), .WIDTH(12)) ib ();

  bcd_to_bin_seq #(.NDIG(4), .WIDTH(11)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  bcd_to_bin_seq #(.NDIG(5), .WIDTH(12)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] bcd;
    logic [11:0] bin;
    logic        ed;
    logic        eo;
  } vec_t;

  vec_t va[10];
  vec_t vb[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge with out_valid high (or after a bound).
  task automatic start_a(input logic [15:0] w, output int lat);
    int n;
    ia.bcd_in   = w;
    ia.in_valid = 1'b1;
    n = 0;
    while (!ia.in_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    ia.in_valid = 1'b0;
    lat = 0;
    while (!ia.out_valid && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic start_b(input logic [19:0] w, output int lat);
    int n;
    ib.bcd_in   = w;
    ib.in_valid = 1'b1;
    n = 0;
    while (!ib.in_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    ib.in_valid = 1'b0;
    lat = 0;
    while (!ib.out_valid && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic drain_a();
    ia.out_ready = 1'b1;
    @(negedge clk);
    ia.out_ready = 1'b0;
    chk("a_drain_out_valid", 32'(ia.out_valid), 32'd0);
    chk("a_drain_in_ready", 32'(ia.in_ready), 32'd1);
  endtask

  task automatic drain_b();
    ib.out_ready = 1'b1;
    @(negedge clk);
    ib.out_ready = 1'b0;
    chk("b_drain_out_valid", 32'(ib.out_valid), 32'd0);
    chk("b_drain_in_ready", 32'(ib.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    errors = 0;
    total  = 0;

    va[0] = '{20'h0A123, 12'h07B, 1'b0, 1'b0};
    va[1] = '{20'h0B999, 12'h419, 1'b0, 1'b0};
    va[2] = '{20'h0BA00, 12'h000, 1'b0, 1'b0};
    va[3] = '{20'h02047, 12'h3FF, 1'b0, 1'b1};
    va[4] = '{20'h01C23, 12'h07B, 1'b1, 1'b0};
    va[5] = '{20'h0BB12, 12'h7F4, 1'b1, 1'b0};
    va[6] = '{20'h01023, 12'h3FF, 1'b0, 1'b0};
    va[7] = '{20'h0FFFF, 12'h000, 1'b0, 1'b0};
    va[8] = '{20'h0EB99, 12'h79D, 1'b1, 1'b0};
    va[9] = '{20'h01B24, 12'h784, 1'b0, 1'b0};

    vb[0] = '{20'hB2048, 12'h800, 1'b0, 1'b0};
    vb[1] = '{20'hB2049, 12'h800, 1'b0, 1'b1};
    vb[2] = '{20'h02047, 12'h7FF, 1'b0, 1'b0};
    vb[3] = '{20'h02048, 12'h7FF, 1'b0, 1'b1};
    vb[4] = '{20'h9999C, 12'h7FF, 1'b1, 1'b1};
    vb[5] = '{20'h0B001, 12'hFFF, 1'b0, 1'b0};

    rst = 1'b1;
    ia.in_valid = 1'b0; ia.bcd_in = '0; ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.bcd_in = '0; ib.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(ia.in_ready), 32'd1);
    chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
    chk("rst_bin_out", 32'(ia.bin_out), 32'd0);
    chk("rst_err_digit", 32'(ia.err_digit), 32'd0);
    chk("rst_err_ovf", 32'(ia.err_ovf), 32'd0);
    chk("rst_b_in_ready", 32'(ib.in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      start_a(va[i].bcd[15:0], lat);
      chk($sformatf("a%0d_latency", i), 32'(lat), 32'd5);
      chk($sformatf("a%0d_bin_out", i), 32'(ia.bin_out), 32'(va[i].bin[10:0]));
      chk($sformatf("a%0d_err_digit", i), 32'(ia.err_digit), 32'(va[i].ed));
      chk($sformatf("a%0d_err_ovf", i), 32'(ia.err_ovf), 32'(va[i].eo));
      drain_a();
    end

    for (int i = 0; i < 6; i++) begin
      start_b(vb[i].bcd, lat);
      chk($sformatf("b%0d_latency", i), 32'(lat), 32'd6);
      chk($sformatf("b%0d_bin_out", i), 32'(ib.bin_out), 32'(vb[i].bin));
      chk($sformatf("b%0d_err_digit", i), 32'(ib.err_digit), 32'(vb[i].ed));
      chk($sformatf("b%0d_err_ovf", i), 32'(ib.err_ovf), 32'(vb[i].eo));
      drain_b();
    end

    // Back-pressure: result must hold while a competing word is offered.
    start_a(16'hA123, lat);
    chk("bp_latency", 32'(lat), 32'd5);
    for (int i = 0; i < 10; i++) begin
      ia.in_valid = i[0];
      ia.bcd_in   = 16'h0777;
      @(negedge clk);
      chk("bp_out_valid", 32'(ia.out_valid), 32'd1);
      chk("bp_in_ready", 32'(ia.in_ready), 32'd0);
      chk("bp_bin_out", 32'(ia.bin_out), 32'h07B);
    end
    ia.in_valid = 1'b0;
    drain_a();
    repeat (3) @(negedge clk);
    chk("idle_hold_bin_out", 32'(ia.bin_out), 32'h07B);
    chk("idle_no_second_word", 32'(ia.out_valid), 32'd0);

    // Reset during the second CONV cycle abandons the word.
    ia.bcd_in   = 16'h0999;
    ia.in_valid = 1'b1;
    @(negedge clk);
    ia.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(ia.in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(ia.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(ia.out_valid), 32'd0);
    chk("mid_rst_bin_out", 32'(ia.bin_out), 32'd0);
    chk("mid_rst_err_digit", 32'(ia.err_digit), 32'd0);
    repeat (8) @(negedge clk);
    chk("mid_rst_no_result", 32'(ia.out_valid), 32'd0);
    start_a(16'hA042, lat);
    chk("post_rst_latency", 32'(lat), 32'd5);
    chk("post_rst_bin_out", 32'(ia.bin_out), 32'h02A);
    chk("post_rst_err_digit", 32'(ia.err_digit), 32'd0);
    drain_a();

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
